// File: rtl/cur_blk_pingpong_pkg.sv
// Shared motion-estimation definitions: default pixel width, clog2 and the
// raster pixel-offset helper used by the current-block, window and SAD blocks.
package cur_blk_pingpong_pkg;

  localparam int PIX_W_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Bit offset of pixel (r,c) in a flat raster-ordered block bus.
  function automatic int pix_lsb(input int r, input int c, input int blk_w, input int pix_w);
    return (r * blk_w + c) * pix_w;
  endfunction

endpackage

// File: rtl/cur_blk_bank.sv
// One block bank: BEATS words of LANES pixels, written one beat at a time,
// cleared asynchronously. Beat k holds raster pixels k*LANES .. k*LANES+LANES-1.
module cur_blk_bank
  import cur_blk_pingpong_pkg::*;
#(
  parameter int BLK_W = 8,
  parameter int BLK_H = 8,
  parameter int PIX_W = PIX_W_DEF,
  parameter int LANES = 4,
  localparam int BEATS = BLK_W * BLK_H / LANES,
  localparam int CW    = clog2(BEATS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [CW-1:0]                  beat_idx,
  input  logic [LANES*PIX_W-1:0]         wdata,
  output logic [BLK_W*BLK_H*PIX_W-1:0]   q
);

  logic [BEATS-1:0][LANES*PIX_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[beat_idx] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign q = mem_q;

endmodule

// File: rtl/cur_blk_pingpong.sv
// Double-buffered current-block register: fills one bank from a raster beat
// stream while the other bank is presented in parallel to the SAD array.
module cur_blk_pingpong
  import cur_blk_pingpong_pkg::*;
#(
  parameter int BLK_W = 8,
  parameter int BLK_H = 8,
  parameter int PIX_W = PIX_W_DEF,
  parameter int LANES = 4,
  localparam int BEATS = BLK_W * BLK_H / LANES,
  localparam int CW    = clog2(BEATS),
  localparam int BW    = BLK_W * BLK_H * PIX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] in_data,
  input  logic                   flush,
  output logic                   blk_valid,
  input  logic                   blk_release,
  output logic [BW-1:0]          blk_data,
  output logic [CW:0]            fill_cnt
);

  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept, last, rel;
  logic [1:0][BW-1:0] bank_q;

  assign in_ready  = !full_q[wr_sel_q];
  assign blk_valid = full_q[rd_sel_q];
  assign blk_data  = bank_q[rd_sel_q];
  assign fill_cnt  = {1'b0, cnt_q};

  assign accept = in_valid && in_ready && !flush;
  assign last   = accept && (cnt_q == CW'(BEATS - 1));
  assign rel    = blk_release && blk_valid;

  // last and rel always target different banks: last needs the write bank
  // empty, rel needs the read bank full.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    cnt_d    = cnt_q;
    if (last) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end
    if (rel) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
    if (flush)       cnt_d = '0;
    else if (last)   cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    cur_blk_bank #(
      .BLK_W(BLK_W), .BLK_H(BLK_H), .PIX_W(PIX_W), .LANES(LANES)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (accept && (wr_sel_q == 1'(b))),
      .beat_idx(cnt_q),
      .wdata   (in_data),
      .q       (bank_q[b])
    );
  end

endmodule

// File: tb/tb_cur_blk_pingpong.sv
// Randomized and directed bench for cur_blk_pingpong against a two-entry
// block FIFO model plus a partially assembled pixel buffer.
module tb_cur_blk_pingpong;
  localparam int BLK_W = 8, BLK_H = 8, PIX_W = 8, LANES = 4;
  localparam int BEATS = BLK_W * BLK_H / LANES;
  localparam int BW = BLK_W * BLK_H * PIX_W;
  localparam int DW = LANES * PIX_W;
  typedef logic [BW-1:0] blk_t;

  logic clk = 0, rst = 1;
  logic in_valid = 0, flush = 0, blk_release = 0;
  logic in_ready, blk_valid;
  logic [DW-1:0] in_data = '0;
  logic [BW-1:0] blk_data;
  logic [4:0] fill_cnt;

  int n_chk = 0, n_pass = 0;

  // Model: completed blocks waiting for the consumer, plus the block being built.
  blk_t fifo[$];
  blk_t part;
  int   pcnt;

  cur_blk_pingpong #(.BLK_W(BLK_W), .BLK_H(BLK_H), .PIX_W(PIX_W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .blk_valid(blk_valid), .blk_release(blk_release),
    .blk_data(blk_data), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    fifo.delete();
    part = '0;
    pcnt = 0;
  endtask

  // Advance one clock edge and update the model from the inputs seen at it.
  task automatic tick();
    bit acc, rel;
    acc = in_valid && (fifo.size() < 2) && !flush;
    rel = blk_release && (fifo.size() > 0);
    @(posedge clk);
    if (rel) void'(fifo.pop_front());
    if (flush) pcnt = 0;
    else if (acc) begin
      for (int i = 0; i < LANES; i++)
        part[(pcnt * LANES + i) * PIX_W +: PIX_W] = in_data[i * PIX_W +: PIX_W];
      pcnt++;
      if (pcnt == BEATS) begin
        fifo.push_back(part);
        pcnt = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; flush = 0; blk_release = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_clear();
  endtask

  function automatic blk_t ramp(input int base);
    blk_t b;
    for (int p = 0; p < BLK_W * BLK_H; p++) b[p * PIX_W +: PIX_W] = PIX_W'(base + p);
    return b;
  endfunction

  function automatic blk_t rnd_blk();
    blk_t b;
    for (int w = 0; w < BW / 32; w++) b[w * 32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic feed(input blk_t b, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      in_valid = 1;
      in_data  = b[k * DW +: DW];
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #2;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", in_ready); else n_pass++;
    n_chk++; if (blk_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", blk_valid); else n_pass++;
    n_chk++; if (fill_cnt !== 5'd0) $display("FAIL rst_fill: got %0d exp 0", fill_cnt); else n_pass++;
    n_chk++; if (blk_data !== '0) $display("FAIL rst_data: got %h exp 0", blk_data); else n_pass++;
    do_reset();
  endtask

  task automatic test_first_fill();
    blk_t exp;
    do_reset();
    for (int r = 0; r < BLK_H; r++)
      for (int c = 0; c < BLK_W; c++) exp[(r * BLK_W + c) * PIX_W +: PIX_W] = PIX_W'(8 * r + c);
    for (int k = 0; k < BEATS; k++) begin
      in_valid = 1;
      in_data  = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      tick();
      n_chk++; if (in_ready !== 1'b1) $display("FAIL ff_ready k=%0d: got %b exp 1", k, in_ready); else n_pass++;
      if (k == BEATS - 2) begin
        n_chk++; if (blk_valid !== 1'b0) $display("FAIL ff_early: got %b exp 0", blk_valid); else n_pass++;
        n_chk++; if (fill_cnt !== 5'(BEATS - 1)) $display("FAIL ff_cnt: got %0d exp %0d", fill_cnt, BEATS - 1); else n_pass++;
      end
    end
    in_valid = 0;
    n_chk++; if (blk_valid !== 1'b1) $display("FAIL ff_valid: got %b exp 1", blk_valid); else n_pass++;
    n_chk++; if (blk_data !== exp) $display("FAIL ff_data: got %h exp %h", blk_data, exp); else n_pass++;
    n_chk++; if (fill_cnt !== 5'd0) $display("FAIL ff_wrap: got %0d exp 0", fill_cnt); else n_pass++;
  endtask

  task automatic test_pingpong();
    blk_t a, b;
    do_reset();
    a = ramp(0); b = ramp(64);
    feed(a, 0, BEATS - 1);
    for (int k = 0; k < BEATS; k++) begin
      feed(b, k, k);
      n_chk++; if (blk_data !== a) $display("FAIL pp_hold k=%0d: got %h exp %h", k, blk_data, a); else n_pass++;
    end
    n_chk++; if (in_ready !== 1'b0) $display("FAIL pp_full: got %b exp 0", in_ready); else n_pass++;
    blk_release = 1; tick(); blk_release = 0;
    n_chk++; if (blk_valid !== 1'b1 || blk_data !== b) $display("FAIL pp_swap: got %b/%h exp 1/%h", blk_valid, blk_data, b); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL pp_ready: got %b exp 1", in_ready); else n_pass++;
    tick();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL pp_ready2: got %b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_overlap();
    blk_t a, b;
    do_reset();
    a = rnd_blk(); b = rnd_blk();
    feed(a, 0, BEATS - 1);
    feed(b, 0, BEATS - 2);
    n_chk++; if (blk_data !== a) $display("FAIL ov_a: got %h exp %h", blk_data, a); else n_pass++;
    blk_release = 1;
    feed(b, BEATS - 1, BEATS - 1);
    blk_release = 0;
    n_chk++; if (blk_valid !== 1'b1) $display("FAIL ov_valid: got %b exp 1", blk_valid); else n_pass++;
    n_chk++; if (blk_data !== b) $display("FAIL ov_data: got %h exp %h", blk_data, b); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL ov_ready: got %b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_flush();
    blk_t aa;
    do_reset();
    aa = {(BW / 8){8'hAA}};
    feed(rnd_blk(), 0, 6);
    n_chk++; if (fill_cnt !== 5'd7) $display("FAIL fl_pre: got %0d exp 7", fill_cnt); else n_pass++;
    flush = 1; in_valid = 1; in_data = $urandom; tick(); flush = 0; in_valid = 0;
    n_chk++; if (fill_cnt !== 5'd0) $display("FAIL fl_cnt: got %0d exp 0", fill_cnt); else n_pass++;
    feed(aa, 0, BEATS - 1);
    n_chk++; if (blk_valid !== 1'b1 || blk_data !== aa) $display("FAIL fl_data: got %b/%h exp 1/%h", blk_valid, blk_data, aa); else n_pass++;
  endtask

  task automatic test_backpressure();
    blk_t a, b, c, d;
    do_reset();
    a = rnd_blk(); b = rnd_blk(); c = rnd_blk(); d = rnd_blk();
    feed(a, 0, BEATS - 1);
    feed(b, 0, BEATS - 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = $urandom; tick();
      n_chk++; if (in_ready !== 1'b0 || fill_cnt !== 5'd0 || blk_data !== a)
        $display("FAIL bp_hold i=%0d: got rdy=%b cnt=%0d data=%h exp 0/0/%h", i, in_ready, fill_cnt, blk_data, a); else n_pass++;
    end
    // Release while still driving a beat: the freed bank must not take it.
    blk_release = 1; tick(); blk_release = 0; in_valid = 0;
    n_chk++; if (fill_cnt !== 5'd0 || in_ready !== 1'b1) $display("FAIL bp_relwr: got cnt=%0d rdy=%b exp 0/1", fill_cnt, in_ready); else n_pass++;
    n_chk++; if (blk_data !== b) $display("FAIL bp_b: got %h exp %h", blk_data, b); else n_pass++;
    blk_release = 1; tick();
    tick(); blk_release = 0;
    n_chk++; if (blk_valid !== 1'b0) $display("FAIL bp_empty: got %b exp 0", blk_valid); else n_pass++;
    feed(c, 0, BEATS - 1);
    feed(d, 0, BEATS - 1);
    n_chk++; if (blk_valid !== 1'b1 || blk_data !== c) $display("FAIL bp_c: got %b/%h exp 1/%h", blk_valid, blk_data, c); else n_pass++;
    blk_release = 1; tick(); blk_release = 0;
    n_chk++; if (blk_valid !== 1'b1 || blk_data !== d) $display("FAIL bp_d: got %b/%h exp 1/%h", blk_valid, blk_data, d); else n_pass++;
  endtask

  task automatic test_async_reset();
    blk_t a;
    do_reset();
    feed(rnd_blk(), 0, BEATS - 1);
    feed(rnd_blk(), 0, 8);
    #2 rst = 1;
    #1;
    n_chk++; if (blk_valid !== 1'b0 || in_ready !== 1'b1 || fill_cnt !== 5'd0 || blk_data !== '0)
      $display("FAIL ar_now: got v=%b r=%b c=%0d d=%h exp 0/1/0/0", blk_valid, in_ready, fill_cnt, blk_data); else n_pass++;
    @(posedge clk); #1 rst = 0;
    model_clear();
    a = rnd_blk();
    feed(a, 0, BEATS - 1);
    n_chk++; if (blk_valid !== 1'b1 || blk_data !== a) $display("FAIL ar_refill: got %b/%h exp 1/%h", blk_valid, blk_data, a); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 39) == 0);
      blk_release = ($urandom_range(0, 9) < 2);
      in_data     = $urandom;
      tick();
      n_chk++;
      if (in_ready !== (fifo.size() < 2) || blk_valid !== (fifo.size() > 0) || fill_cnt !== 5'(pcnt) ||
          (fifo.size() > 0 && blk_data !== fifo[0])) begin
        if (errs < 10) $display("FAIL rnd cyc=%0d: got rdy=%b v=%b cnt=%0d exp rdy=%b v=%b cnt=%0d",
                                i, in_ready, blk_valid, fill_cnt, fifo.size() < 2, fifo.size() > 0, pcnt);
        errs++;
      end else n_pass++;
    end
    in_valid = 0; flush = 0; blk_release = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_fill();
    test_pingpong();
    test_overlap();
    test_flush();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
